dmem_responder: RTL

- Multi-cycle data-memory slave that answers load/store requests issued by the pipeline MEM stage.
- Supports word, half and byte accesses with lane steering, a configurable response latency, and misalignment reporting.
- Sits between the EX/MEM register outputs and the MEM/WB register; the pipeline stalls on `busy`.
- Sign extension of loaded bytes/halves stays in the WB stage; this block returns zero-extended lane data.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_unit.sv | 61 ++++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-enable helper used by the lane unit.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Little-endian byte enables; the reserved size 2'b11 behaves as a word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane steering: merges store data into the old word, extracts
// zero-extended load data and flags misalignment (macro DMEM_ALIGN_CHECK_EN).
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        misaligned
);

    logic [1:0]  eff_lo;
    logic [3:0]  be;
    logic [31:0] lane_data;
    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        eff_lo     = addr_lo;
        misaligned = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        case (size)
            SZ_HALF: misaligned = addr_lo[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = (addr_lo != 2'b00);
        endcase
`else
        // Without the check, bits below the access size are simply dropped.
        case (size)
            SZ_HALF: eff_lo = {addr_lo[1], 1'b0};
            SZ_BYTE: eff_lo = addr_lo;
            default: eff_lo = 2'b00;
        endcase
`endif
        be = byte_enable(size, eff_lo);

        case (size)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase

        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end

        shifted = old_word >> {eff_lo, 3'b000};
        case (size)
            SZ_BYTE: rd_data = {24'h0, shifted[7:0]};
            SZ_HALF: rd_data = {16'h0, shifted[15:0]};
            default: rd_data = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave for the MEM stage with lane steering and a
// fixed response latency; misalignment reporting needs DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 7,
    parameter int LATENCY     = 2     // legal range 1..15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [ADDR_W+1:0] op_addr;
    logic [1:0]        op_size;
    logic              op_write;
    logic [31:0]       op_wdata;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       old_word;
    logic [31:0]       lane_wr;
    logic [31:0]       lane_rd;
    logic              lane_mis;
    logic              enter_resp;
    logic              mem_we;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // live request has to feed the lane unit instead of the capture registers.
    assign op_addr  = (state_q == IDLE) ? req_addr[ADDR_W+1:0] : addr_q;
    assign op_size  = (state_q == IDLE) ? req_size  : size_q;
    assign op_write = (state_q == IDLE) ? req_write : write_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign op_idx   = op_addr[ADDR_W+1:2];
    assign old_word = mem_q[op_idx];

    dmem_lane_unit u_lane (
        .size       (op_size),
        .addr_lo    (op_addr[1:0]),
        .wdata      (op_wdata),
        .old_word   (old_word),
        .wr_word    (lane_wr),
        .rd_data    (lane_rd),
        .misaligned (lane_mis)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        enter_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:0];
                    size_d  = req_size;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = lane_mis;
            resp_rdata_d = (op_write || lane_mis) ? 32'h0 : lane_rd;
        end
    end

    assign mem_we = enter_resp && op_write && !lane_mis;

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            size_q       <= SZ_WORD;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the array has no reset; Reset only suppresses an in-flight store.
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            mem_q[op_idx] <= lane_wr;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
